bios_failover_ctrl: RTL and testbench

- Supervises CPU boot from two QSPI BIOS banks (main = bank 0, second = bank 1).
- Watches the BMC heartbeat (1 Hz square wave on BMC_GPIO0). On boot timeout or heartbeat loss it swaps banks and issues a CPU POR pulse. After repeated failures it locks out.
- Also schedules BMC-driven BIOS updates: routes QSPI chip-select to the target bank, then reboots from main.
- Sits between the I2C register block (update requests), the ms timer chain (tick_1ms) and the QSPI CSN / R_CPU_POR_N pins.

---
 rtl/bios_ctrl_pkg.sv | 24 ++
 rtl/bios_hb_monitor.sv | 25 ++
 rtl/bios_failover_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_bios_failover_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bios_ctrl_pkg.sv
// Shared definitions for the dual-bank BIOS failover controller:
// FSM state encoding, bank identifiers and the chip-select gating helper.
package bios_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_BOOT_WAIT   = 3'd1,
    ST_RUN         = 3'd2,
    ST_FAILOVER    = 3'd3,
    ST_UPDATE      = 3'd4,
    ST_RESET_PULSE = 3'd5,
    ST_LOCKOUT     = 3'd6
  } state_t;

  localparam logic BANK_MAIN   = 1'b0;
  localparam logic BANK_SECOND = 1'b1;

  // A flash sees the CPU/BMC chip-select only when it is the routed bank and not blocked.
  function automatic logic gate_csn(input logic csn, input logic route,
                                    input logic bank, input logic blocked);
    return (blocked || (route != bank)) ? 1'b1 : csn;
  endfunction

endpackage

// File: rtl/bios_hb_monitor.sv
// Two-flop synchronizer followed by an any-edge detector for a slow asynchronous level.
// any_edge pulses for one clk, three clk edges after the pin changes.
module bios_hb_monitor (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic any_edge
);

  logic [1:0] sync_reg;
  logic       dly_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
      dly_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      dly_reg  <= sync_reg[1];
    end
  end

  assign any_edge = sync_reg[1] ^ dly_reg;

endmodule

// File: rtl/bios_failover_ctrl.sv
// Boot supervisor for two QSPI BIOS banks: heartbeat/boot watchdog, bank failover with
// CPU POR pulse, retry lockout, and BMC-driven update routing with glitch-free bank switching.
module bios_failover_ctrl
  import bios_ctrl_pkg::*;
#(
  parameter int BOOT_TIMEOUT_MS = 120000,
  parameter int HB_LOSS_MS      = 2000,
  parameter int POR_PULSE_MS    = 100,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       boot_start,
  input  logic       heartbeat,
  input  logic       upd_req,
  input  logic       upd_target,
  input  logic       upd_done,
  input  logic       csn_in,
  output logic       csn0_out,
  output logic       csn1_out,
  output logic       por_n,
  output logic       active_bank,
  output logic [2:0] state_o,
  output logic [1:0] fail_cnt
);

  // Limits are compared against the pre-tick count so the limit-th tick itself fires.
  localparam logic [CNT_W-1:0] BOOT_LIM  = CNT_W'(BOOT_TIMEOUT_MS - 1);
  localparam logic [CNT_W-1:0] HB_LIM    = CNT_W'(HB_LOSS_MS - 1);
  localparam logic [CNT_W-1:0] POR_LIM   = CNT_W'(POR_PULSE_MS - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       fail_reg;
  logic             active_bank_reg;
  logic             pending_bank_reg;
  logic             route_reg;
  logic             upd_target_reg;
  logic             por_n_reg;
  logic [1:0]       csn_sync_reg;

  logic hb_edge;
  logic boot_hit;
  logic hb_hit;
  logic por_hit;
  logic retry_last;
  logic blocked;
  logic [1:0] csn_vec;

  bios_hb_monitor u_hb_monitor (
    .clk      (clk),
    .rst      (rst),
    .raw      (heartbeat),
    .any_edge (hb_edge)
  );

  assign boot_hit   = tick_1ms && (cnt_reg >= BOOT_LIM);
  assign hb_hit     = tick_1ms && (cnt_reg >= HB_LIM);
  assign por_hit    = tick_1ms && (cnt_reg >= POR_LIM);
  assign retry_last = ({1'b0, fail_reg} + 3'd1) >= {1'b0, RETRY_LIM};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_sync_reg <= 2'b11;
    end else begin
      csn_sync_reg <= {csn_sync_reg[0], csn_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      fail_reg         <= 2'd0;
      active_bank_reg  <= BANK_MAIN;
      pending_bank_reg <= BANK_MAIN;
      route_reg        <= BANK_MAIN;
      upd_target_reg   <= BANK_MAIN;
      por_n_reg        <= 1'b1;
    end else begin
      if (tick_1ms && !(&cnt_reg)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      // Bank changes land only while the flash is deselected.
      if (csn_sync_reg[1]) begin
        active_bank_reg <= pending_bank_reg;
        route_reg       <= (state_reg == ST_UPDATE) ? upd_target_reg : pending_bank_reg;
      end

      unique case (state_reg)
        ST_IDLE: begin
          if (boot_start) begin
            state_reg <= ST_BOOT_WAIT;
            cnt_reg   <= '0;
          end
        end
        ST_BOOT_WAIT: begin
          if (hb_edge) begin
            cnt_reg <= '0;
          end
          if (boot_hit && !hb_edge) begin
            state_reg <= ST_FAILOVER;
            cnt_reg   <= '0;
          end else if (upd_req) begin
            upd_target_reg <= upd_target;
            state_reg      <= ST_UPDATE;
            cnt_reg        <= '0;
          end else if (hb_edge) begin
            fail_reg  <= 2'd0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (hb_edge) begin
            cnt_reg <= '0;
          end
          if (hb_hit && !hb_edge) begin
            state_reg <= ST_FAILOVER;
            cnt_reg   <= '0;
          end else if (upd_req) begin
            upd_target_reg <= upd_target;
            state_reg      <= ST_UPDATE;
            cnt_reg        <= '0;
          end
        end
        ST_FAILOVER: begin
          cnt_reg <= '0;
          if (retry_last) begin
            fail_reg  <= RETRY_LIM;
            state_reg <= ST_LOCKOUT;
          end else begin
            fail_reg         <= fail_reg + 2'd1;
            pending_bank_reg <= ~active_bank_reg;
            por_n_reg        <= 1'b0;
            state_reg        <= ST_RESET_PULSE;
          end
        end
        ST_RESET_PULSE: begin
          if (por_hit) begin
            por_n_reg <= 1'b1;
            state_reg <= ST_BOOT_WAIT;
            cnt_reg   <= '0;
          end
        end
        ST_UPDATE: begin
          if (upd_done) begin
            pending_bank_reg <= BANK_MAIN;
            fail_reg         <= 2'd0;
            por_n_reg        <= 1'b0;
            state_reg        <= ST_RESET_PULSE;
            cnt_reg          <= '0;
          end
        end
        ST_LOCKOUT: begin
          if (upd_req) begin
            upd_target_reg <= upd_target;
            state_reg      <= ST_UPDATE;
            cnt_reg        <= '0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign blocked = (state_reg == ST_LOCKOUT) || (state_reg == ST_RESET_PULSE);

  for (genvar gi = 0; gi < 2; gi++) begin : g_csn
    assign csn_vec[gi] = gate_csn(csn_in, route_reg, (gi == 1), blocked);
  end

  assign csn0_out    = csn_vec[0];
  assign csn1_out    = csn_vec[1];
  assign por_n       = por_n_reg;
  assign active_bank = active_bank_reg;
  assign state_o     = state_reg;
  assign fail_cnt    = fail_reg;

endmodule

// File: tb/tb_bios_failover_ctrl.sv
// Randomized self-checking bench for bios_failover_ctrl, with short ms limits so every
// watchdog path, lockout, update and reset scenario completes quickly.
module tb_bios_failover_ctrl;

  localparam int BT = 40;
  localparam int HB = 20;
  localparam int PP = 10;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       boot_start = 1'b0;
  logic       heartbeat = 1'b0;
  logic       upd_req = 1'b0;
  logic       upd_target = 1'b0;
  logic       upd_done = 1'b0;
  logic       csn_in = 1'b1;
  logic       csn0_out;
  logic       csn1_out;
  logic       por_n;
  logic       active_bank;
  logic [2:0] state_o;
  logic [1:0] fail_cnt;

  int checks = 0;
  int failures = 0;
  int state_ticks = 0;
  int prev_ticks = 0;
  int pulse_ticks = 0;
  int inv_bad = 0;
  int hb_cnt = 0;
  bit csn_rand = 1'b0;

  // Reference model: expected bank and consecutive-failure count.
  int m_bank = 0;
  int m_fail = 0;

  bios_failover_ctrl #(
    .BOOT_TIMEOUT_MS (BT),
    .HB_LOSS_MS      (HB),
    .POR_PULSE_MS    (PP),
    .MAX_RETRY       (MR),
    .CNT_W           (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1ms    (tick_1ms),
    .boot_start  (boot_start),
    .heartbeat   (heartbeat),
    .upd_req     (upd_req),
    .upd_target  (upd_target),
    .upd_done    (upd_done),
    .csn_in      (csn_in),
    .csn0_out    (csn0_out),
    .csn1_out    (csn1_out),
    .por_n       (por_n),
    .active_bank (active_bank),
    .state_o     (state_o),
    .fail_cnt    (fail_cnt)
  );

  always #10 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock; tick accounting is attributed to the state held before the edge.
  task automatic step(input bit t);
    logic [2:0] sb;
    logic       pb;
    if (csn_rand) csn_in = 1'($urandom_range(0, 1));
    sb = state_o;
    pb = por_n;
    tick_1ms = t;
    @(posedge clk);
    #1;
    tick_1ms = 1'b0;
    boot_start = 1'b0;
    upd_req = 1'b0;
    upd_done = 1'b0;
    if (t && !pb) pulse_ticks++;
    if (t) state_ticks++;
    if (state_o != sb) begin
      prev_ticks = state_ticks;
      state_ticks = 0;
    end
    if (!csn0_out && !csn1_out) inv_bad++;
    if (csn_in && !(csn0_out && csn1_out)) inv_bad++;
    if ((por_n == 1'b0) != (state_o == 3'd5)) inv_bad++;
    if ((state_o == 3'd5 || state_o == 3'd6) && !(csn0_out && csn1_out)) inv_bad++;
  endtask

  // One millisecond: random idle gap, optional heartbeat toggle, then the tick.
  task automatic ms(input int hb_per);
    int gap;
    gap = $urandom_range(0, 2);
    if (hb_per > 0) begin
      hb_cnt++;
      if (hb_cnt >= hb_per) begin
        heartbeat = ~heartbeat;
        hb_cnt = 0;
      end
    end
    repeat (gap) step(1'b0);
    step(1'b1);
  endtask

  task automatic run_until_leave(input string tag, input logic [2:0] st, input int max_ms);
    int n;
    n = 0;
    while (state_o == st && n < max_ms) begin
      ms(0);
      n++;
    end
    check_eq(tag, (state_o != st), 1);
  endtask

  task automatic settle_csn();
    csn_rand = 1'b0;
    csn_in = 1'b1;
    repeat (3) step(1'b0);
  endtask

  task automatic pulse_phase(input string tag);
    check_eq({tag, "_in_pulse"}, state_o, 5);
    pulse_ticks = 0;
    run_until_leave({tag, "_pulse_end"}, 3'd5, 3 * PP);
    check_eq({tag, "_pulse_ticks"}, pulse_ticks, PP);
    check_eq({tag, "_post_pulse"}, state_o, 1);
  endtask

  initial begin
    int n;
    int tgt;
    logic [1:0] exp_csn;

    repeat (3) @(posedge clk);
    #1;
    csn_in = 1'b0;
    #1;
    check_eq("rst_state", state_o, 0);
    check_eq("rst_por_n", por_n, 1);
    check_eq("rst_bank", active_bank, 0);
    check_eq("rst_fail", fail_cnt, 0);
    check_eq("rst_csn0", csn0_out, 0);
    check_eq("rst_csn1", csn1_out, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    csn_in = 1'b1;

    // Normal boot into RUN on the main bank.
    boot_start = 1'b1;
    step(1'b0);
    check_eq("boot_wait", state_o, 1);
    repeat ($urandom_range(5, 30)) ms(0);
    heartbeat = ~heartbeat;
    n = 0;
    while (state_o != 3'd2 && n < 6) begin
      step(1'b0);
      n++;
    end
    check_eq("boot_run", state_o, 2);
    check_eq("boot_run_latency_ok", (n <= 3), 1);
    check_eq("boot_fail", fail_cnt, m_fail);
    check_eq("boot_bank", active_bank, m_bank);
    csn_rand = 1'b1;
    pulse_ticks = 0;
    hb_cnt = 0;
    n = $urandom_range(3, 15);
    repeat (60) ms(n);
    csn_rand = 1'b0;
    check_eq("run_hold", state_o, 2);
    check_eq("run_no_por", pulse_ticks, 0);
    csn_in = 1'b0;
    step(1'b0);
    check_eq("run_csn0_low", csn0_out, 0);
    check_eq("run_csn1_idle", csn1_out, 1);
    csn_in = 1'b1;
    step(1'b0);
    check_eq("run_csn0_high", csn0_out, 1);

    // Heartbeat loss with the flash held selected across the switch.
    csn_in = 1'b0;
    heartbeat = ~heartbeat;
    repeat (4) step(1'b0);
    state_ticks = 0;
    run_until_leave("hbloss_wait", 3'd2, 3 * HB);
    check_eq("hbloss_fo", state_o, 3);
    check_eq("hbloss_ticks", prev_ticks, HB);
    m_fail++;
    step(1'b0);
    check_eq("hbloss_fail", fail_cnt, m_fail);
    pulse_phase("hbloss");
    check_eq("hbloss_bank_held", active_bank, m_bank);
    check_eq("hbloss_csn0_held", csn0_out, 0);
    check_eq("hbloss_csn1_held", csn1_out, 1);
    m_bank ^= 1;
    settle_csn();
    check_eq("hbloss_bank_new", active_bank, m_bank);
    csn_in = 1'b0;
    step(1'b0);
    check_eq("hbloss_csn1_route", csn1_out, 0);
    check_eq("hbloss_csn0_idle", csn0_out, 1);

    // Boot timeouts until lockout.
    csn_rand = 1'b1;
    for (int it = 0; it < 4; it++) begin
      run_until_leave("to_wait", 3'd1, 2 * BT);
      check_eq("to_fo", state_o, 3);
      check_eq("to_ticks", prev_ticks, BT);
      step(1'b0);
      if (m_fail + 1 >= MR) begin
        m_fail = MR;
        check_eq("lock_state", state_o, 6);
        break;
      end
      m_fail++;
      m_bank ^= 1;
      pulse_phase("to");
      settle_csn();
      check_eq("to_bank", active_bank, m_bank);
      check_eq("to_fail", fail_cnt, m_fail);
      csn_rand = 1'b1;
    end
    repeat (20) ms(0);
    csn_rand = 1'b0;
    csn_in = 1'b0;
    step(1'b0);
    check_eq("lock_hold", state_o, 6);
    check_eq("lock_fail", fail_cnt, MR);
    check_eq("lock_csn0", csn0_out, 1);
    check_eq("lock_csn1", csn1_out, 1);
    check_eq("lock_por_n", por_n, 1);
    upd_done = 1'b1;
    step(1'b0);
    check_eq("lock_ignore_done", state_o, 6);

    // Update out of lockout to a random bank.
    tgt = $urandom_range(0, 1);
    upd_req = 1'b1;
    upd_target = 1'(tgt);
    step(1'b0);
    check_eq("lupd_state", state_o, 4);
    settle_csn();
    csn_in = 1'b0;
    step(1'b0);
    exp_csn = (tgt == 0) ? 2'b10 : 2'b01;
    check_eq("lupd_csn0", csn0_out, exp_csn[0]);
    check_eq("lupd_csn1", csn1_out, exp_csn[1]);
    upd_done = 1'b1;
    csn_in = 1'b1;
    step(1'b0);
    m_bank = 0;
    m_fail = 0;
    pulse_phase("lupd");
    settle_csn();
    check_eq("lupd_bank", active_bank, m_bank);
    check_eq("lupd_fail", fail_cnt, m_fail);

    // Timeout and update request on the same clock: failover wins.
    while (state_ticks < BT - 1) ms(0);
    upd_req = 1'b1;
    upd_target = 1'($urandom_range(0, 1));
    step(1'b1);
    check_eq("race_to_wins", state_o, 3);
    m_fail++;
    m_bank ^= 1;
    step(1'b0);
    pulse_phase("race");
    settle_csn();
    check_eq("race_bank", active_bank, m_bank);
    check_eq("race_fail", fail_cnt, m_fail);

    // Heartbeat edge and timeout on the same clock: heartbeat wins.
    while (state_ticks < BT - 1) ms(0);
    heartbeat = ~heartbeat;
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check_eq("race_hb_wins", state_o, 2);
    m_fail = 0;
    check_eq("race_hb_fail", fail_cnt, m_fail);

    // Update of the main bank while running from the second one.
    upd_done = 1'b1;
    step(1'b0);
    check_eq("run_ignore_done", state_o, 2);
    upd_req = 1'b1;
    upd_target = 1'b0;
    step(1'b0);
    check_eq("rupd_state", state_o, 4);
    settle_csn();
    csn_in = 1'b0;
    step(1'b0);
    check_eq("rupd_csn0", csn0_out, 0);
    check_eq("rupd_csn1", csn1_out, 1);
    upd_done = 1'b1;
    csn_in = 1'b1;
    step(1'b0);
    upd_req = 1'b1;
    step(1'b0);
    check_eq("pulse_ignore_req", state_o, 5);
    m_bank = 0;
    m_fail = 0;
    pulse_phase("rupd");
    settle_csn();
    check_eq("rupd_bank", active_bank, m_bank);
    check_eq("rupd_fail", fail_cnt, m_fail);

    // Asynchronous reset in the middle of a POR pulse.
    run_until_leave("rstp_wait", 3'd1, 2 * BT);
    step(1'b0);
    repeat (4) ms(0);
    check_eq("rstp_por_low", por_n, 0);
    #5;
    rst = 1'b1;
    #1;
    check_eq("rstp_por_n", por_n, 1);
    check_eq("rstp_state", state_o, 0);
    check_eq("rstp_bank", active_bank, 0);
    check_eq("rstp_fail", fail_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("invariants", inv_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
